// File: rtl/arb21_if.sv
// arb21_if -- request/grant bundle between two requesters and the arb21 arbiter.
//
// Handshake: a requester raises req_x and keeps it high for its whole transfer.
// It owns the shared path on every cycle where gnt_x is high. Dropping req_x
// ends the transfer. There is no queuing: a request that was dropped and raised
// again is arbitrated as a new request.
//
// Signals
//   req_a, req_b : requests from A and B
//   a, b         : requester data, W bits each
//   gnt_a, gnt_b : registered grants (never both high)
//   sel          : shared-path select, 0 = A, 1 = B
//   z            : registered shared-path data, W bits
//   busy         : high while any grant is active
interface arb21_if #(
    parameter int W = 1
);
    logic         req_a;
    logic         req_b;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gnt_a;
    logic         gnt_b;
    logic         sel;
    logic         busy;
    logic [W-1:0] z;

    // Requester side: drives requests and data, observes grants.
    modport master (
        output req_a, req_b, a, b,
        input  gnt_a, gnt_b, sel, busy, z
    );

    // Arbiter side.
    modport slave (
        input  req_a, req_b, a, b,
        output gnt_a, gnt_b, sel, busy, z
    );
endinterface

// File: rtl/arb21.sv
// arb21 -- two-requester arbiter driving a registered shared 2:1 data path.
//
// Simultaneous requests from idle are resolved by alternating priority (the
// requester not granted most recently wins). An owner can hold the path for at
// most MAX_HOLD consecutive cycles while the other requester is waiting; with no
// competition it keeps the grant indefinitely.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : arb21_if slave modport (requests, data, grants, sel, busy, z)
//   dbg_state : current FSM state (0 = IDLE, 1 = GRANT_A, 2 = GRANT_B)
module arb21 #(
    parameter int W        = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    arb21_if.slave       bus,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t       state;
    state_t       next_state;
    logic         last;      // 0 = A granted most recently, 1 = B
    logic [7:0]   hcnt;
    logic [W-1:0] z_q;

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    next_state = last ? GRANT_A : GRANT_B;
                end else if (bus.req_a) begin
                    next_state = GRANT_A;
                end else if (bus.req_b) begin
                    next_state = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!bus.req_a) begin
                    next_state = bus.req_b ? GRANT_B : IDLE;
                end else if (bus.req_b && (hcnt == HOLD_LAST)) begin
                    next_state = GRANT_B;
                end
            end
            GRANT_B: begin
                if (!bus.req_b) begin
                    next_state = bus.req_a ? GRANT_A : IDLE;
                end else if (bus.req_a && (hcnt == HOLD_LAST)) begin
                    next_state = GRANT_A;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State, hold counter, and priority record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            hcnt  <= 8'd0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                hcnt <= 8'd0;
                // Entering IDLE leaves the priority record alone.
                if (next_state != IDLE) begin
                    last <= (next_state == GRANT_B);
                end
            end else if ((state != IDLE) && (hcnt != HOLD_LAST)) begin
                hcnt <= hcnt + 8'd1;
            end
        end
    end

    // Shared path: muxed on the pre-edge owner, so z trails the grant by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= '0;
        end else begin
            unique case (state)
                GRANT_A: z_q <= bus.a;
                GRANT_B: z_q <= bus.b;
                default: z_q <= '0;
            endcase
        end
    end

    assign bus.gnt_a = (state == GRANT_A);
    assign bus.gnt_b = (state == GRANT_B);
    assign bus.sel   = (state == GRANT_B);
    assign bus.busy  = (state == GRANT_A) || (state == GRANT_B);
    assign bus.z     = z_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_arb21.sv
module tb_arb21;

    localparam int W        = 8;
    localparam int MAX_HOLD = 4;
    localparam int EW       = W + 4;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb21_if #(.W(W)) bus ();

    arb21 #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = A, 2 = B. held: cycles the owner has had the path.
    int m_owner;
    int m_last;
    int m_held;

    function automatic logic [EW-1:0] pack(input logic ga, input logic gb,
                                           input logic s, input logic bz,
                                           input logic [W-1:0] zz);
        return {ga, gb, s, bz, zz};
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_held  = 0;
    endtask

    task automatic model_step(input logic ra, input logic rb,
                              input logic [W-1:0] da, input logic [W-1:0] db);
        logic [W-1:0] zn;
        int nxt;
        zn  = (m_owner == 1) ? da : (m_owner == 2) ? db : '0;
        nxt = m_owner;
        if (m_owner == 0) begin
            if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
        end else begin
            logic mine, other;
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine)                            nxt = other ? 3 - m_owner : 0;
            else if (other && m_held >= MAX_HOLD) nxt = 3 - m_owner;
        end
        if (nxt != m_owner) begin
            m_held = (nxt != 0) ? 1 : 0;
            if (nxt != 0) m_last = nxt;
        end else if (m_owner != 0) begin
            m_held++;
        end
        m_owner = nxt;
        exp_q.push_back(pack(nxt == 1, nxt == 2, nxt == 2, nxt != 0, zn));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ra, input logic rb,
                         input logic [W-1:0] da, input logic [W-1:0] db);
        @(negedge clk);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.a     = da;
        bus.b     = db;
        model_step(ra, rb, da, db);
    endtask

    task automatic drive_n(input int n, input logic ra, input logic rb);
        for (int i = 0; i < n; i++) begin
            drive(ra, rb, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [EW-1:0] got;
        got = pack(bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.z);
        checks++;
        if (got !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL %s: got %h state %0d, expected all zero, state 0", name, got, dbg_state);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] got;
        logic [EW-1:0] exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = pack(bus.gnt_a, bus.gnt_b, bus.sel, bus.busy, bus.z);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle @%0t: got {ga,gb,sel,busy,z}=%h expected %h", $time, got, exp);
            end
            checks++;
            if (bus.gnt_a && bus.gnt_b) begin
                errors++;
                $display("FAIL mutex @%0t: got both grants high, expected at most one", $time);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Tie from reset goes to A, then alternate every MAX_HOLD cycles.
        drive_n(12, 1'b1, 1'b1);
        drive_n(2, 1'b0, 1'b0);

        // Uncontested owner holds well past MAX_HOLD, then hands off at once.
        drive_n(20, 1'b1, 1'b0);
        drive_n(3, 1'b1, 1'b1);
        drive_n(2, 1'b0, 1'b0);

        // Owner A drops while B waits: direct switch, busy stays high.
        drive_n(3, 1'b1, 1'b0);
        drive_n(3, 1'b0, 1'b1);
        drive_n(1, 1'b0, 1'b0);

        // Both drop while A owns, then a tie goes to B.
        drive_n(3, 1'b1, 1'b0);
        drive_n(2, 1'b0, 1'b0);
        drive_n(3, 1'b1, 1'b1);
        drive_n(2, 1'b0, 1'b0);

        // Reset in the middle of a B grant.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h5A, 8'hC3);
        reset_pulse();
        drive_n(2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h5A, 8'hC3);
        drive_n(1, 1'b0, 1'b0);

        // Randomized traffic with bursty requests.
        begin
            logic ra, rb;
            ra = 1'b0;
            rb = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) ra = ~ra;
                if ($urandom_range(0, 5) == 0) rb = ~rb;
                drive(ra, rb, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
                if (i == 200) reset_pulse();
            end
        end
        drive_n(3, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb21.md
ARB21 -- requirements
Module: arb21

Interface
REQ-001 Parameter W, default 1: width of data inputs A, B and output Z.
REQ-002 Parameter MAX_HOLD, default 8: max consecutive grant cycles for one requester while the other is requesting; legal range 2..255.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_A  input  1  requester A wants the shared path; held high for the whole transfer.
REQ-006 REQ_B  input  1  requester B wants the shared path; held high for the whole transfer.
REQ-007 A  input  W  requester A data.
REQ-008 B  input  W  requester B data.
REQ-009 GNT_A  output  1  registered grant to A.
REQ-010 GNT_B  output  1  registered grant to B.
REQ-011 SEL  output  1  select for the shared 2:1 path; 0 = A, 1 = B.
REQ-012 Z  output  W  registered shared-path data.
REQ-013 BUSY  output  1  high whenever any grant is active.

Function
REQ-014 FSM states: IDLE, GRANT_A, GRANT_B; GNT_A = (state==GRANT_A), GNT_B = (state==GRANT_B), BUSY = GNT_A|GNT_B, SEL = (state==GRANT_B).
REQ-015 1-bit LAST register records the most recently granted requester (0 = A, 1 = B).
REQ-016 IDLE: REQ_A only -> GRANT_A; REQ_B only -> GRANT_B; both -> grant to the requester not equal to LAST; neither -> stay IDLE.
REQ-017 Grant latency: request sampled high at edge N in IDLE -> grant high after edge N (one cycle).
REQ-018 GRANT_A: REQ_A low and REQ_B high -> GRANT_B directly (no IDLE bubble); REQ_A low and REQ_B low -> IDLE.
REQ-019 GRANT_B: symmetric to REQ-018.
REQ-020 8-bit hold counter HCNT cleared on every state change, incremented each cycle in a grant state, saturating at MAX_HOLD-1.
REQ-021 Forced handoff: in GRANT_A with REQ_A high, REQ_B high and HCNT==MAX_HOLD-1 -> GRANT_B at that edge; symmetric for GRANT_B.
REQ-022 Owner keeps grant indefinitely while the other requester is low; HCNT stays saturated; handoff occurs on the first edge the other requests.
REQ-023 LAST updated to the newly granted requester on every entry to GRANT_A/GRANT_B; unchanged on entry to IDLE.
REQ-024 Z at each edge <= A if pre-edge state GRANT_A, B if GRANT_B, all-zeros if IDLE; Z lags grant by one cycle.
REQ-025 Never GNT_A and GNT_B high together; a switch A->B drops GNT_A and raises GNT_B on the same edge.
REQ-026 Requests arriving for the current owner after it drops (re-request) are arbitrated as new requests per REQ-016/018; no queuing.

Reset
REQ-027 RST_N low asynchronously forces state IDLE, LAST=1 (A wins first tie), HCNT=0, GNT_A=0, GNT_B=0, SEL=0, BUSY=0, Z=0.
REQ-028 Reset mid-grant aborts the transfer immediately; no grant resumes after release without a fresh sampled request.
REQ-029 First edge after RST_N rises evaluates IDLE transitions normally.

Verification
REQ-030 Reset, then REQ_A=REQ_B=1 at edge 1 -> GNT_A=1 after edge 1, Z=A after edge 2, SEL=0.
REQ-031 MAX_HOLD=4, both held high -> grant pattern A,A,A,A,B,B,B,B,A... with GNT switching every 4 cycles, never both high.
REQ-032 GNT_A active, REQ_B low, REQ_A held 20 cycles -> GNT_A stays 1 for all 20; REQ_B raised at cycle 21 -> GNT_B next edge.
REQ-033 GNT_A active, REQ_A drops while REQ_B=1 -> GNT_B=1, SEL=1 on that edge; Z shows B one cycle later; BUSY stays 1.
REQ-034 GNT_B active, A=8'h5A, B=8'hC3 (W=8), RST_N pulsed low between edges -> all outputs 0 immediately; Z=8'h00 until a new grant plus one cycle.
REQ-035 Both requests drop same cycle while GNT_A -> IDLE, BUSY=0, Z=0 one cycle later; next simultaneous request grants B (LAST=A).
